// File: rtl/panda_pkg.sv
// Shared types for the panda data-memory port: responder FSM states and
// the request/response bundles seen at the LSU boundary.
package panda_pkg;

  localparam int unsigned DMEM_BE_W   = 4;
  localparam logic [15:0] LFSR16_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_e;

  typedef struct packed {
    logic [31:0]          addr;
    logic                 we;
    logic [DMEM_BE_W-1:0] be;
    logic [31:0]          wdata;
  } dmem_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;

endpackage

// File: rtl/panda_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form), seeded on reset.
module panda_lfsr16
  import panda_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     lfsr_q <= LFSR16_SEED;
    else if (en_i) lfsr_q <= {fb, lfsr_q[15:1]};
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/panda_dmem_responder.sv
// Target end of the LSU req/gnt/rvalid data port backed by an on-chip RAM.
// Define PANDA_DMEM_GNT_STALL_EN to insert pseudo-random grant stalls.
module panda_dmem_responder
  import panda_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [31:0]          addr_i,
  input  logic                 we_i,
  input  logic [DMEM_BE_W-1:0] be_i,
  input  logic [31:0]          wdata_i,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o
);

  localparam int unsigned IW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  dmem_req_t   req;
  dmem_rsp_t   rsp_q;
  dmem_state_e state_q;
  logic [3:0]  cnt_q;
  logic [31:0] pend_data_q;
  logic        pend_err_q;
  logic [31:0] ram [DEPTH_WORDS];

  logic [32:0]   off;
  logic [IW-1:0] idx;
  logic          in_range, gnt, stall, accept;
  logic [31:0]   rd_word;
  logic          unused_ok;

  assign req = '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};

  // Range check on the full offset; truncation to the index happens only after.
  assign off      = {1'b0, req.addr} - {1'b0, BASE_ADDR};
  assign in_range = (req.addr >= BASE_ADDR) && (off < SPAN);
  assign idx      = off[IW+1:2];

`ifdef PANDA_DMEM_GNT_STALL_EN
  logic [15:0] lfsr;
  panda_lfsr16 u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (1'b1),
    .value_o (lfsr)
  );
  assign stall     = lfsr[0];
  assign unused_ok = ^{off[32:IW+2], off[1:0], lfsr[15:1]};
`else
  assign stall     = 1'b0;
  assign unused_ok = ^{off[32:IW+2], off[1:0]};
`endif

  assign gnt    = !rst_i && (state_q != DMEM_WAIT) && !stall;
  assign accept = req_i && gnt;
  assign gnt_o  = gnt;

  // RAM is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (accept && req.we && in_range)
      for (int b = 0; b < DMEM_BE_W; b++)
        if (req.be[b]) ram[idx][8*b +: 8] <= req.wdata[8*b +: 8];
  end

  assign rd_word = (!req.we && in_range) ? ram[idx] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= DMEM_IDLE;
      cnt_q       <= '0;
      rsp_q       <= '0;
      pend_data_q <= '0;
      pend_err_q  <= 1'b0;
    end else begin
      rsp_q <= '0;
      case (state_q)
        DMEM_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= DMEM_RESP;
            rsp_q   <= '{rvalid: 1'b1, rdata: pend_data_q, err: pend_err_q};
          end
        end
        default: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state_q <= DMEM_RESP;
              rsp_q   <= '{rvalid: 1'b1, rdata: rd_word, err: !in_range};
            end else begin
              state_q     <= DMEM_WAIT;
              cnt_q       <= LAT - 4'd1;
              pend_data_q <= rd_word;
              pend_err_q  <= !in_range;
            end
          end else begin
            state_q <= DMEM_IDLE;
          end
        end
      endcase
    end
  end

  assign rvalid_o = rsp_q.rvalid;
  assign rdata_o  = rsp_q.rdata;
  assign err_o    = rsp_q.err;

endmodule

// File: tb/tb_panda_dmem_responder.sv
// Directed bench: three responders (LATENCY 1, 3, 4) sharing a clock and reset.
module tb_panda_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req    [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        err    [3];
  logic [31:0] addr, wdata;
  logic        we;
  logic [3:0]  be;

  int checks = 0;
  int errors = 0;
  int gnt_low = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    panda_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(L)) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req[g]),
      .gnt_o    (gnt[g]),
      .addr_i   (addr),
      .we_i     (we),
      .be_i     (be),
      .wdata_i  (wdata),
      .rvalid_o (rvalid[g]),
      .rdata_o  (rdata[g]),
      .err_o    (err[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present a request, hold it until granted, return 1 time unit after the accept edge.
  task automatic do_req(input int i, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
    int n = 0;
    req[i] = 1'b1; addr = a; we = w; be = b; wdata = d;
    while (!gnt[i] && n < 100) begin
      gnt_low++;
      @(negedge clk);
      n++;
    end
    if (!gnt[i]) chk("gnt_timeout", 0, 1);
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  // LATENCY=1 transaction: response is visible right after the accept edge.
  task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, input logic e, input logic [31:0] x,
                     input string tag);
    do_req(0, w, a, b, d);
    chk(tag, {rvalid[0], err[0], rdata[0]}, {1'b1, e, x});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nrv;
    rst = 1'b1; addr = '0; we = 1'b0; be = '0; wdata = '0;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk("rst_outputs", {gnt[i], rvalid[i], err[i], rdata[i]}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk("idle_outputs", {rvalid[i], err[i], rdata[i]}, 64'h0);
`ifndef PANDA_DMEM_GNT_STALL_EN
    chk("idle_gnt", gnt[0], 1'b1);
`endif

    // Write then read the same word back-to-back.
    txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        "wr_ack_10");
    txn(1'b0, 32'h10, 4'h0, 32'h0,        1'b0, 32'hDEADBEEF, "rd_10");

    // Byte enables, including an all-zero no-op write.
    txn(1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, 32'h0,        "wr_ack_20");
    txn(1'b1, 32'h20, 4'h2, 32'h0000AA00, 1'b0, 32'h0,        "wr_be2_ack");
    txn(1'b0, 32'h20, 4'h0, 32'h0,        1'b0, 32'h1122AA44, "rd_be_merge");
    txn(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0,        "wr_be0_ack");
    txn(1'b0, 32'h20, 4'h0, 32'h0,        1'b0, 32'h1122AA44, "rd_be0_nochange");

    // Out of range: no aliasing onto word 0; top word still valid.
    txn(1'b1, 32'h0,      4'hF, 32'h5A5A1234, 1'b0, 32'h0,        "wr_ack_0");
    txn(1'b1, 32'h1000,   4'hF, 32'hFFFFFFFF, 1'b1, 32'h0,        "wr_oor_err");
    txn(1'b0, 32'h0,      4'h0, 32'h0,        1'b0, 32'h5A5A1234, "rd_0_unchanged");
    txn(1'b1, 32'hFFC,    4'hF, 32'h0BADCAFE, 1'b0, 32'h0,        "wr_ack_last");
    txn(1'b0, 32'hFFC,    4'h0, 32'h0,        1'b0, 32'h0BADCAFE, "rd_last");
    txn(1'b0, 32'hFFFFFFFC, 4'h0, 32'h0,      1'b1, 32'h0,        "rd_oor_err");
    @(posedge clk); #1;
    chk("rvalid_drops", {rvalid[0], err[0], rdata[0]}, 64'h0);

    // LATENCY=3: grant low for two cycles, response on the third.
    do_req(1, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D);
    chk("l3_t1", {gnt[1], rvalid[1]}, 2'b00);
    @(posedge clk); #1;
    chk("l3_t2", {gnt[1], rvalid[1]}, 2'b00);
    @(posedge clk); #1;
    chk("l3_wr_ack", {rvalid[1], err[1], rdata[1]}, {1'b1, 1'b0, 32'h0});
`ifndef PANDA_DMEM_GNT_STALL_EN
    chk("l3_gnt_resp", gnt[1], 1'b1);
`endif
    do_req(1, 1'b0, 32'h40, 4'h0, 32'h0);
    chk("l3_rd_t1", {gnt[1], rvalid[1]}, 2'b00);
    @(posedge clk); #1;
    chk("l3_rd_t2", {gnt[1], rvalid[1]}, 2'b00);
    @(posedge clk); #1;
    chk("l3_rd", {rvalid[1], err[1], rdata[1]}, {1'b1, 1'b0, 32'hCAFEF00D});

    // LATENCY=4 with reset landing mid-transaction.
    do_req(2, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {gnt[2], rvalid[2], err[2], rdata[2]}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req[2] = 1'b1; addr = 32'h0; we = 1'b0;
    #1;
`ifndef PANDA_DMEM_GNT_STALL_EN
    chk("gnt_after_rst", gnt[2], 1'b1);
`endif
    req[2] = 1'b0;
    nrv = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rvalid[2]) nrv++;
    end
    chk("no_rsp_after_rst", nrv, 0);

`ifdef PANDA_DMEM_GNT_STALL_EN
    begin
      logic [31:0] mdl [16];
      for (int k = 0; k < 16; k++) begin
        mdl[k] = $urandom;
        txn(1'b1, 32'(k * 4), 4'hF, mdl[k], 1'b0, 32'h0, "rnd_init");
      end
      gnt_low = 0;
      for (int n = 0; n < 1000; n++) begin
        logic        w, e;
        logic [3:0]  b;
        logic [31:0] d, x, a;
        int          k;
        w = 1'($urandom_range(0, 1));
        k = $urandom_range(0, 17);
        b = 4'($urandom);
        d = $urandom;
        e = (k >= 16);
        a = e ? 32'(32'h2000 + k * 4) : 32'(k * 4);
        x = (!w && !e) ? mdl[k] : 32'h0;
        if (w && !e)
          for (int j = 0; j < 4; j++) if (b[j]) mdl[k][8*j +: 8] = d[8*j +: 8];
        txn(w, a, b, d, e, x, "rnd_rsp");
      end
      chk("gnt_low_seen", gnt_low > 0, 1'b1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/panda_dmem_responder.md
Name: panda_dmem_responder

Overview:
- Memory-side responder for the core's load/store data port: the target end of the LSU request/grant/rvalid interface.
- Accepts one word-addressed request per grant, applies byte enables on writes, and returns read data or a write acknowledge after a fixed latency.
- Sits between the MEM stage's data port and an on-chip data RAM; flags out-of-range addresses as bus errors.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, >=2
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4
- LATENCY, 1, cycles from grant to rvalid; range 1..15

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req_i  in  1  request valid from LSU
- gnt_o  out  1  request accepted this cycle when req_i && gnt_o
- addr_i  in  32  byte address; bits [1:0] ignored
- we_i  in  1  1=store, 0=load
- be_i  in  4  byte enables, bit n covers wdata_i[8n+7:8n]
- wdata_i  in  32  store data, lane-aligned by LSU
- rvalid_o  out  1  response valid, exactly one cycle per accepted request
- rdata_o  out  32  full read word; 0 on writes and errors
- err_o  out  1  qualifies rvalid_o; address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4)

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt_o=0 during reset, rvalid_o=0, rdata_o=0, err_o=0, wait counter=0. RAM contents are not cleared.
- Clock-related timing:
  - gnt_o is combinational: 1 in IDLE and in RESP, 0 in WAIT.
  - Accept on req_i && gnt_o at cycle T.
- States:
  - IDLE -> (accept) -> LATENCY==1 ? RESP : WAIT, with cnt=LATENCY-1.
  - WAIT: cnt decrements each cycle; at cnt==1 -> RESP.
  - RESP: rvalid_o=1 for this one cycle. If a new request is accepted in the same cycle -> RESP/WAIT per rule above; else -> IDLE.
- Sustained throughput at LATENCY=1 is one request per cycle.
- Writes:
  - RAM updated at the accept edge, bytes with be_i[n]=1 only.
  - be_i=0 is a legal no-op write and is still acknowledged.
- Reads:
  - RAM word sampled at the accept edge into a response register; held until rvalid_o.
  - A read accepted the cycle after a write to the same word returns the new data.
- Error:
  - Out-of-range request is still granted; no RAM write occurs.
  - Response has err_o=1 and rdata_o=0.
  - Index = (addr_i-BASE_ADDR)>>2, truncated to clog2(DEPTH_WORDS) bits only after the range check.
- req_i deasserted without grant: no effect; the master must hold addr/we/be/wdata stable while req_i && !gnt_o.
- rvalid_o, err_o and rdata_o are registered outputs; outside rvalid_o, rdata_o=0 and err_o=0.
- Reset mid-transaction discards the pending response; no rvalid_o after release.

Optional Feature:
- Macro PANDA_DMEM_GNT_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - When LFSR[0]=1, gnt_o is forced 0 in IDLE/RESP.
  - State machine otherwise unchanged; exercises LSU/pipeline stall paths.
- Undefined: no LFSR logic; gnt_o per base rules.

Decomposition:
- panda_pkg additions:
  - dmem_state_e enum (DMEM_IDLE, DMEM_WAIT, DMEM_RESP)
  - localparam DMEM_BE_W=4
  - struct dmem_req_t {addr, we, be, wdata}
  - struct dmem_rsp_t {rvalid, rdata, err}
- One sub-module: panda_lfsr16 (clk_i, rst_i, en_i, value_o), instantiated only under PANDA_DMEM_GNT_STALL_EN; reusable elsewhere.

Test Plan:
- Reset, LATENCY=1:
  - Write addr 0x10, be=4'hF, wdata 0xDEADBEEF, then read 0x10 next cycle.
  - Required: rvalid_o at T+1 (write ack, rdata 0) and T+2 with rdata_o=0xDEADBEEF, err_o=0.
- Byte enables:
  - Write 0x20 = 0x11223344 (be F), then write be=4'b0010 data 0x0000AA00, then read.
  - Required: rdata_o=0x1122AA44.
- LATENCY=3:
  - Read accepted at T.
  - Required: gnt_o=0 at T+1..T+2, rvalid_o only at T+3; back-to-back requests spaced 3 cycles.
- Out of range (DEPTH_WORDS=1024, BASE 0):
  - Write 0x1000 data 0xFFFFFFFF.
  - Required: rvalid_o with err_o=1, rdata_o=0; subsequent read of 0x0 returns its unchanged prior value.
- Reset mid-op:
  - LATENCY=4, assert rst_i at T+2.
  - Required: rvalid_o, err_o, rdata_o=0 immediately; no rvalid_o after release; gnt_o=1 the first cycle after release with req_i=1.
- Stall macro defined:
  - 1000 random reads/writes vs. scoreboard.
  - Required: every accepted request gets exactly one in-order response, data matches model, and gnt_o is low at least once.
